// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner sharing one external BCD decoder.
// Latency: load_ack one cycle after load; a frame is 4 x (REFRESH_DIV+BLANK_CYCLES); no backpressure, loads never stall.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        lz_blank,
  input  logic [6:0]  segment7,
  output logic [3:0]  BCD,
  output logic [6:0]  seg_out,
  output logic [3:0]  an,
  output logic        load_ack,
  output logic        bcd_err
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shad_q, shad_d;
  logic          pend_q, pend_d;
  logic          blank_q, blank_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          load_ok;
  logic          enter_gap;

  function automatic logic nib_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  // Digit k is a leading zero when it and every higher digit are zero.
  function automatic logic lz_hide(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd1:    return v[15:4] == 12'd0;
      2'd2:    return v[15:8] == 8'd0;
      2'd3:    return v[15:12] == 4'd0;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    shad_d    = shad_q;
    pend_d    = pend_q;
    blank_d   = blank_q;
    bcd_d     = bcd_q;
    seg_d     = seg_q;
    an_d      = an_q;
    ack_d     = load;
    err_d     = err_q;
    enter_gap = 1'b0;
    load_ok   = load && nib_ok(value_in);

    if (load) err_d = !load_ok;
    if (load_ok && state_q != IDLE) begin
      shad_d = value_in;
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        an_d = 4'hF;
        if (load_ok) begin
          disp_d    = value_in;
          idx_d     = 2'd0;
          cnt_d     = '0;
          state_d   = GAP;
          enter_gap = 1'b1;
        end
      end
      GAP: begin
        // Decoder output for bcd_q is captured while the anodes are off.
        seg_d = blank_q ? 7'h00 : segment7;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          an_d    = blank_q ? 4'hF : ~(4'b0001 << idx_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d     = '0;
          state_d   = GAP;
          idx_d     = idx_q + 2'd1;
          an_d      = 4'hF;
          enter_gap = 1'b1;
          // Frame boundary: the newest shadow value (including one loaded this cycle) takes over.
          if (idx_q == 2'd3 && pend_d) begin
            disp_d = shad_d;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        an_d    = 4'hF;
      end
    endcase

    if (enter_gap) begin
      bcd_d   = disp_d[{idx_d, 2'b00} +: 4];
      blank_d = lz_blank && lz_hide(disp_d, idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      disp_q  <= 16'h0000;
      shad_q  <= 16'h0000;
      pend_q  <= 1'b0;
      blank_q <= 1'b0;
      bcd_q   <= 4'h0;
      seg_q   <= 7'h00;
      an_q    <= 4'hF;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      pend_q  <= pend_d;
      blank_q <= blank_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign BCD      = bcd_q;
  assign seg_out  = seg_q;
  assign an       = an_q;
  assign load_ack = ack_q;
  assign bcd_err  = err_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=1.
// The shared decoder is modelled inside the bench and fed from BCD.
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic        lz_blank;
  logic [6:0]  segment7;
  logic [3:0]  BCD;
  logic [6:0]  seg_out;
  logic [3:0]  an;
  logic        load_ack;
  logic        bcd_err;

  int tests_run;
  int tests_failed;

  logic [3:0] an_exp [4];

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign segment7 = dec7(BCD);

  seven_seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value_in (value_in),
    .lz_blank (lz_blank),
    .segment7 (segment7),
    .BCD      (BCD),
    .seg_out  (seg_out),
    .an       (an),
    .load_ack (load_ack),
    .bcd_err  (bcd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tests_run++;
    if (an !== 4'hF || seg_out !== 7'h00 || BCD !== 4'h0 || load_ack !== 1'b0 || bcd_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: an=%h seg=%h BCD=%h ack=%b err=%b, expected F 00 0 0 0",
               an, seg_out, BCD, load_ack, bcd_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (an !== 4'hF || seg_out !== 7'h00 || load_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: an=%h seg=%h ack=%b, expected F 00 0", i, an, seg_out, load_ack);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] ex [2][4];
    logic [3:0] d;
    ex = '{'{4'd4, 4'd3, 4'd2, 4'd1}, '{4'd4, 4'd3, 4'd2, 4'd1}};
    value_in = 16'h1234;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tests_run++;
    if (load_ack !== 1'b1 || bcd_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ack: ack=%b err=%b, expected 1 0", load_ack, bcd_err);
    end
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        d = ex[f][s];
        tests_run++;
        if (an !== 4'hF || BCD !== d) begin
          tests_failed++;
          $display("FAIL basic_gap f%0d s%0d: an=%h BCD=%h, expected F %h", f, s, an, BCD, d);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
          if (f == 0 && s == 0 && c == 0) begin
            tests_run++;
            if (load_ack !== 1'b0) begin
              tests_failed++;
              $display("FAIL basic_ack_pulse: ack=%b, expected 0", load_ack);
            end
          end
          tests_run++;
          if (an !== an_exp[s] || seg_out !== dec7(d)) begin
            tests_failed++;
            $display("FAIL basic_show f%0d s%0d c%0d: an=%h seg=%h, expected %h %h",
                     f, s, c, an, seg_out, an_exp[s], dec7(d));
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] ex [4];
    logic       bl [2][4];
    logic [3:0] ea;
    logic [6:0] es;
    ex = '{4'd0, 4'd5, 4'd0, 4'd0};
    bl = '{'{1'b0, 1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0}};
    do_reset();
    lz_blank = 1'b1;
    value_in = 16'h0050;
    load     = 1'b1;
    tick();
    load = 1'b0;
    for (int f = 0; f < 2; f++) begin
      if (f == 1) lz_blank = 1'b0;
      for (int s = 0; s < 4; s++) begin
        tests_run++;
        if (an !== 4'hF || BCD !== ex[s]) begin
          tests_failed++;
          $display("FAIL lz_gap f%0d s%0d: an=%h BCD=%h, expected F %h", f, s, an, BCD, ex[s]);
        end
        tick();
        ea = bl[f][s] ? 4'hF : an_exp[s];
        es = bl[f][s] ? 7'h00 : dec7(ex[s]);
        for (int c = 0; c < 4; c++) begin
          tests_run++;
          if (an !== ea || seg_out !== es) begin
            tests_failed++;
            $display("FAIL lz_show f%0d s%0d c%0d: an=%h seg=%h, expected %h %h", f, s, c, an, seg_out, ea, es);
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_bcd_err();
    logic [3:0] ex [3][4];
    logic [3:0] d;
    logic       inj;
    logic       err_exp;
    ex = '{'{4'd4, 4'd3, 4'd2, 4'd1}, '{4'd4, 4'd3, 4'd2, 4'd1}, '{4'd1, 4'd0, 4'd0, 4'd0}};
    do_reset();
    lz_blank = 1'b0;
    value_in = 16'h1234;
    load     = 1'b1;
    tick();
    load    = 1'b0;
    inj     = 1'b0;
    err_exp = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        d = ex[f][s];
        tests_run++;
        if (an !== 4'hF || BCD !== d || bcd_err !== err_exp) begin
          tests_failed++;
          $display("FAIL err_gap f%0d s%0d: an=%h BCD=%h err=%b, expected F %h %b", f, s, an, BCD, bcd_err, d, err_exp);
        end
        if (s == 0 && f < 2) begin
          value_in = (f == 0) ? 16'h12A4 : 16'h0001;
          load     = 1'b1;
          inj      = 1'b1;
          err_exp  = (f == 0);
        end
        tick();
        load = 1'b0;
        for (int c = 0; c < 4; c++) begin
          if (inj) begin
            inj = 1'b0;
            tests_run++;
            if (load_ack !== 1'b1 || bcd_err !== err_exp) begin
              tests_failed++;
              $display("FAIL err_ack f%0d: ack=%b err=%b, expected 1 %b", f, load_ack, bcd_err, err_exp);
            end
          end
          tests_run++;
          if (an !== an_exp[s] || seg_out !== dec7(d)) begin
            tests_failed++;
            $display("FAIL err_show f%0d s%0d c%0d: an=%h seg=%h, expected %h %h",
                     f, s, c, an, seg_out, an_exp[s], dec7(d));
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    int         s;
    do_reset();
    value_in = 16'h1111;
    load     = 1'b1;
    tick();
    value_in = 16'h2222;
    tests_run++;
    if (load_ack !== 1'b1 || an !== 4'hF || BCD !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_ack0: ack=%b an=%h BCD=%h, expected 1 F 1", load_ack, an, BCD);
    end
    tick();
    value_in = 16'h3333;
    tests_run++;
    if (load_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ack1: ack=%b, expected 1", load_ack);
    end
    tick();
    load = 1'b0;
    tests_run++;
    if (load_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ack2: ack=%b, expected 1", load_ack);
    end
    tick();
    tests_run++;
    if (load_ack !== 1'b0 || an !== 4'hE || seg_out !== dec7(4'd1)) begin
      tests_failed++;
      $display("FAIL b2b_ack_end: ack=%b an=%h seg=%h, expected 0 E %h", load_ack, an, seg_out, dec7(4'd1));
    end
    tick();
    tick();
    for (int k = 1; k < 8; k++) begin
      s = k % 4;
      d = (k < 4) ? 4'd1 : 4'd3;
      tests_run++;
      if (an !== 4'hF || BCD !== d) begin
        tests_failed++;
        $display("FAIL b2b_gap k%0d: an=%h BCD=%h, expected F %h", k, an, BCD, d);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
        tests_run++;
        if (an !== an_exp[s] || seg_out !== dec7(d)) begin
          tests_failed++;
          $display("FAIL b2b_show k%0d c%0d: an=%h seg=%h, expected %h %h", k, c, an, seg_out, an_exp[s], dec7(d));
        end
        tick();
      end
    end
  endtask

  task automatic test_mid_frame_load();
    logic [3:0] ex [2][4];
    logic [3:0] d;
    logic       inj;
    ex = '{'{4'd4, 4'd3, 4'd2, 4'd1}, '{4'd8, 4'd7, 4'd6, 4'd5}};
    do_reset();
    value_in = 16'h1234;
    load     = 1'b1;
    tick();
    load = 1'b0;
    inj  = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        d = ex[f][s];
        tests_run++;
        if (an !== 4'hF || BCD !== d) begin
          tests_failed++;
          $display("FAIL mid_gap f%0d s%0d: an=%h BCD=%h, expected F %h", f, s, an, BCD, d);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
          if (inj) begin
            inj  = 1'b0;
            load = 1'b0;
            tests_run++;
            if (load_ack !== 1'b1) begin
              tests_failed++;
              $display("FAIL mid_ack: ack=%b, expected 1", load_ack);
            end
          end
          tests_run++;
          if (an !== an_exp[s] || seg_out !== dec7(d)) begin
            tests_failed++;
            $display("FAIL mid_show f%0d s%0d c%0d: an=%h seg=%h, expected %h %h",
                     f, s, c, an, seg_out, an_exp[s], dec7(d));
          end
          if (f == 0 && s == 1 && c == 1) begin
            value_in = 16'h5678;
            load     = 1'b1;
            inj      = 1'b1;
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    tests_run++;
    if (an !== 4'hE || seg_out !== dec7(4'd8)) begin
      tests_failed++;
      $display("FAIL areset_pre: an=%h seg=%h, expected E %h", an, seg_out, dec7(4'd8));
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (an !== 4'hF || seg_out !== 7'h00 || BCD !== 4'h0 || load_ack !== 1'b0 || bcd_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_now: an=%h seg=%h BCD=%h ack=%b err=%b, expected F 00 0 0 0",
               an, seg_out, BCD, load_ack, bcd_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (an !== 4'hF || seg_out !== 7'h00 || load_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL areset_idle cyc%0d: an=%h seg=%h ack=%b, expected F 00 0", i, an, seg_out, load_ack);
      end
    end
    value_in = 16'h0009;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tests_run++;
    if (an !== 4'hE || seg_out !== dec7(4'd9)) begin
      tests_failed++;
      $display("FAIL areset_reload: an=%h seg=%h, expected E %h", an, seg_out, dec7(4'd9));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    an_exp       = '{4'hE, 4'hD, 4'hB, 4'h7};
    rst_n        = 1'b0;
    load         = 1'b0;
    value_in     = 16'h0000;
    lz_blank     = 1'b0;
    test_reset();
    test_basic_scan();
    test_lz_blank();
    test_bcd_err();
    test_back_to_back();
    test_mid_frame_load();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
